hamming_ecc_unit: RTL and testbench

SECDED Hamming(39,32) codec between the core's data-memory port and the 39-bit storage array. It encodes store data into a 39-bit codeword and decodes and corrects load codewords. Single-bit errors are corrected and double-bit errors are flagged, both combinationally in the same cycle. A small clocked block counts corrected and uncorrectable events and captures the last syndrome for diagnostics.

---
 rtl/hamming_ecc_unit_pkg.sv | 29 ++
 rtl/hamming_secded_core.sv | 84 ++++++++
 rtl/hamming_ecc_unit.sv | 61 ++++++
 tb/tb_hamming_ecc_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hamming_ecc_unit_pkg.sv
// Shared widths, check-bit positions and index mapping for the SECDED(39,32) codec.
package hamming_ecc_unit_pkg;

    localparam int DATA_W = 32;
    localparam int CODE_W = 39;
    localparam int SYN_W  = 6;

    localparam int CHK_POS0 = 1;
    localparam int CHK_POS1 = 2;
    localparam int CHK_POS2 = 4;
    localparam int CHK_POS3 = 8;
    localparam int CHK_POS4 = 16;
    localparam int CHK_POS5 = 32;

    // Data bits skip every power-of-two position, so the offset grows by one per check bit passed.
    function automatic logic [5:0] data_pos(input int i);
        if (i < 1)       data_pos = 6'd3;
        else if (i < 4)  data_pos = 6'(i + 4);
        else if (i < 11) data_pos = 6'(i + 5);
        else if (i < 26) data_pos = 6'(i + 6);
        else             data_pos = 6'(i + 7);
    endfunction

    function automatic logic is_chk_pos(input int p);
        is_chk_pos = (p == CHK_POS0) || (p == CHK_POS1) || (p == CHK_POS2) ||
                     (p == CHK_POS3) || (p == CHK_POS4) || (p == CHK_POS5);
    endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Combinational SECDED(39,32) encode, syndrome generation and single-bit correction.
module hamming_secded_core
    import hamming_ecc_unit_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [CODE_W-1:0] code_in,
    output logic [CODE_W-1:0] code_out,
    output logic [DATA_W-1:0] data_out,
    output logic [SYN_W-1:0]  syn,
    output logic              par,
    output logic              s_err,
    output logic              d_err
);

    logic [CODE_W-1:0] w_dpos;
    logic [SYN_W-1:0]  w_chk;
    logic [CODE_W-1:0] w_enc;
    logic [CODE_W-1:0] w_fix;
    logic              w_fix_en;

    always_comb begin
        w_dpos = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_dpos[data_pos(i)] = data_in[i];
        end
    end

    always_comb begin
        w_chk = '0;
        for (int k = 0; k < SYN_W; k++) begin
            for (int p = 1; p < CODE_W; p++) begin
                if (!is_chk_pos(p) && p[k]) begin
                    w_chk[k] = w_chk[k] ^ w_dpos[p];
                end
            end
        end
    end

    always_comb begin
        w_enc = w_dpos;
        w_enc[CHK_POS0] = w_chk[0];
        w_enc[CHK_POS1] = w_chk[1];
        w_enc[CHK_POS2] = w_chk[2];
        w_enc[CHK_POS3] = w_chk[3];
        w_enc[CHK_POS4] = w_chk[4];
        w_enc[CHK_POS5] = w_chk[5];
        w_enc[0] = ^w_enc[CODE_W-1:1];
    end

    assign code_out = w_enc;

    always_comb begin
        syn = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (code_in[p]) begin
                syn = syn ^ 6'(p);
            end
        end
    end

    assign par = ^code_in;

    // Odd overall parity with a syndrome naming no real position cannot be a single flip.
    assign w_fix_en = par && (syn != '0) && (syn <= 6'(CODE_W - 1));
    assign s_err    = par && (syn <= 6'(CODE_W - 1));
    assign d_err    = (par && (syn > 6'(CODE_W - 1))) || (!par && (syn != '0));

    always_comb begin
        w_fix = code_in;
        for (int p = 1; p < CODE_W; p++) begin
            if (w_fix_en && (syn == 6'(p))) begin
                w_fix[p] = ~code_in[p];
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_out[i] = w_fix[data_pos(i)];
        end
    end

endmodule

// File: rtl/hamming_ecc_unit.sv
// SECDED(39,32) memory codec with saturating error counters and last-syndrome capture.
module hamming_ecc_unit
    import hamming_ecc_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CODE_W-1:0] code_in,
    input  logic              check_en,
    input  logic              clr_cnt,
    output logic [CODE_W-1:0] code_out,
    output logic [DATA_W-1:0] data_out,
    output logic              s_err,
    output logic              d_err,
    output logic [15:0]       s_err_cnt,
    output logic [15:0]       d_err_cnt,
    output logic [6:0]        last_syn
);

    logic [SYN_W-1:0] w_syn;
    logic             w_par;
    logic [15:0]      r_s_cnt;
    logic [15:0]      r_d_cnt;
    logic [6:0]       r_last_syn;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    hamming_secded_core u_core (
        .data_in  (data_in),
        .code_in  (code_in),
        .code_out (code_out),
        .data_out (data_out),
        .syn      (w_syn),
        .par      (w_par),
        .s_err    (s_err),
        .d_err    (d_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_cnt    <= '0;
            r_d_cnt    <= '0;
            r_last_syn <= '0;
        end else if (clr_cnt) begin
            r_s_cnt    <= '0;
            r_d_cnt    <= '0;
            r_last_syn <= '0;
        end else if (check_en) begin
            if (s_err) r_s_cnt <= sat_inc(r_s_cnt);
            if (d_err) r_d_cnt <= sat_inc(r_d_cnt);
            if (s_err || d_err) r_last_syn <= {w_par, w_syn};
        end
    end

    assign s_err_cnt = r_s_cnt;
    assign d_err_cnt = r_d_cnt;
    assign last_syn  = r_last_syn;

endmodule

// File: tb/tb_hamming_ecc_unit.sv
// Directed bench for hamming_ecc_unit with hand-computed codewords and counter checks.
module tb_hamming_ecc_unit;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [38:0] code_in;
    logic        check_en;
    logic        clr_cnt;
    logic [38:0] code_out;
    logic [31:0] data_out;
    logic        s_err;
    logic        d_err;
    logic [15:0] s_err_cnt;
    logic [15:0] d_err_cnt;
    logic [6:0]  last_syn;

    int total = 0;
    int bad   = 0;

    hamming_ecc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .code_in   (code_in),
        .check_en  (check_en),
        .clr_cnt   (clr_cnt),
        .code_out  (code_out),
        .data_out  (data_out),
        .s_err     (s_err),
        .d_err     (d_err),
        .s_err_cnt (s_err_cnt),
        .d_err_cnt (d_err_cnt),
        .last_syn  (last_syn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        data_in  = 32'h0;
        code_in  = 39'h0;
        check_en = 1'b0;
        clr_cnt  = 1'b0;
        #1;
        chk("rst_s_cnt", 64'(s_err_cnt), 64'h0);
        chk("rst_d_cnt", 64'(d_err_cnt), 64'h0);
        chk("rst_last",  64'(last_syn),  64'h0);
        tick();
        rst = 1'b1;
        tick();

        data_in = 32'h0; code_in = 39'h0; #1;
        chk("enc_zero",   64'(code_out), 64'h0);
        chk("dec_zero",   64'(data_out), 64'h0);
        chk("zero_s_err", 64'(s_err),    64'h0);
        chk("zero_d_err", 64'(d_err),    64'h0);

        data_in = 32'h1; code_in = 39'h0F; #1;
        chk("enc_one",   64'(code_out), 64'h0F);
        chk("dec_one",   64'(data_out), 64'h1);
        chk("one_s_err", 64'(s_err),    64'h0);
        chk("one_d_err", 64'(d_err),    64'h0);

        data_in = 32'h2; #1;
        chk("enc_two", 64'(code_out), 64'h33);
        data_in = 32'h8000_0000; #1;
        chk("enc_msb", 64'(code_out), 64'h41_0000_0014);
        code_in = 39'h41_0000_0014; #1;
        chk("dec_msb", 64'(data_out), 64'h8000_0000);

        // Single flip at position 5
        code_in = 39'h2F; check_en = 1'b1; #1;
        chk("sgl_data",  64'(data_out), 64'h1);
        chk("sgl_s_err", 64'(s_err),    64'h1);
        chk("sgl_d_err", 64'(d_err),    64'h0);
        tick();
        chk("sgl_s_cnt", 64'(s_err_cnt), 64'h1);
        chk("sgl_last",  64'(last_syn),  64'h45);

        // Double flip at positions 5 and 6
        code_in = 39'h6F; #1;
        chk("dbl_d_err", 64'(d_err),    64'h1);
        chk("dbl_s_err", 64'(s_err),    64'h0);
        chk("dbl_data",  64'(data_out), 64'h7);
        tick();
        chk("dbl_d_cnt", 64'(d_err_cnt), 64'h1);
        chk("dbl_s_cnt", 64'(s_err_cnt), 64'h1);
        chk("dbl_last",  64'(last_syn),  64'h03);

        // Flip of the overall parity bit only
        code_in = 39'h0E; #1;
        chk("p0_data",  64'(data_out), 64'h1);
        chk("p0_s_err", 64'(s_err),    64'h1);
        chk("p0_d_err", 64'(d_err),    64'h0);
        tick();
        chk("p0_s_cnt", 64'(s_err_cnt), 64'h2);
        chk("p0_last",  64'(last_syn),  64'h40);

        // Odd parity with syndrome 63: beyond any real position
        code_in = 39'h1_8000_0001; #1;
        chk("big_d_err", 64'(d_err),    64'h1);
        chk("big_s_err", 64'(s_err),    64'h0);
        chk("big_data",  64'(data_out), 64'h0200_0000);
        tick();
        chk("big_d_cnt", 64'(d_err_cnt), 64'h2);
        chk("big_last",  64'(last_syn),  64'h7F);

        check_en = 1'b0; code_in = 39'h2F;
        tick();
        chk("noen_s_cnt", 64'(s_err_cnt), 64'h2);
        chk("noen_last",  64'(last_syn),  64'h7F);

        check_en = 1'b1; code_in = 39'h0F;
        tick();
        chk("clean_s_cnt", 64'(s_err_cnt), 64'h2);
        chk("clean_d_cnt", 64'(d_err_cnt), 64'h2);
        chk("clean_last",  64'(last_syn),  64'h7F);

        clr_cnt = 1'b1; code_in = 39'h2F;
        tick();
        clr_cnt = 1'b0;
        chk("clr_s_cnt", 64'(s_err_cnt), 64'h0);
        chk("clr_d_cnt", 64'(d_err_cnt), 64'h0);
        chk("clr_last",  64'(last_syn),  64'h0);

        repeat (70000) @(posedge clk);
        #1;
        chk("sat_s_cnt", 64'(s_err_cnt), 64'hFFFF);
        chk("sat_d_cnt", 64'(d_err_cnt), 64'h0);

        code_in = 39'h6F;
        tick();
        chk("pre_rst_d_cnt", 64'(d_err_cnt), 64'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_s_cnt", 64'(s_err_cnt), 64'h0);
        chk("arst_d_cnt", 64'(d_err_cnt), 64'h0);
        chk("arst_last",  64'(last_syn),  64'h0);
        chk("arst_comb",  64'(d_err),     64'h1);
        #2;
        rst = 1'b1;
        tick();
        chk("resume_d_cnt", 64'(d_err_cnt), 64'h1);
        chk("resume_last",  64'(last_syn),  64'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
